// File: rtl/n64_poll_scheduler_if.sv
// Transaction handshake between the poll scheduler and the N64 bit-level serial engine.
//   master (scheduler): drives txn_start/txn_cmd/txn_rx_len, receives busy/done/err/rx_data
//   slave  (engine)   : the mirror image
//   txn_start   1  one-cycle start pulse, cmd/rx_len valid in the same cycle
//   txn_cmd     8  command byte
//   txn_rx_len  6  expected response length in bits
//   txn_busy    1  engine busy; a start is only issued while low
//   txn_done    1  one-cycle end-of-transaction pulse
//   txn_err     1  error flag, qualified by txn_done
//   txn_rx_data 32 right-justified response, valid with txn_done
interface n64_poll_scheduler_if;
    logic        txn_start;
    logic [7:0]  txn_cmd;
    logic [5:0]  txn_rx_len;
    logic        txn_busy;
    logic        txn_done;
    logic        txn_err;
    logic [31:0] txn_rx_data;

    modport master (
        output txn_start, txn_cmd, txn_rx_len,
        input  txn_busy, txn_done, txn_err, txn_rx_data
    );

    modport slave (
        input  txn_start, txn_cmd, txn_rx_len,
        output txn_busy, txn_done, txn_err, txn_rx_data
    );
endinterface

// File: rtl/n64_poll_scheduler.sv
// N64 poll scheduler: arbitrates the single serial engine between the periodic button poll,
// controller-reset requests and status requests; issues start handshakes, applies timeout and
// retry, and latches response data.
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_polling_enable      level, enables periodic poll ticks
//   i_reset_req           level, rising edge requests a controller reset (cmd 0xFF)
//   i_status_req          pulse, requests a status read (cmd 0x00)
//   txn_if                master side of the engine handshake
//   o_button_data         last good poll response
//   o_status_data         last good reset/status response
//   o_data_valid          button_data holds a good response from the latest poll attempt
//   o_controller_present  latest transaction (after retries) succeeded
//   o_err_count           saturating count of transactions that failed after all retries
module n64_poll_scheduler #(
    parameter int unsigned POLL_PERIOD  = 100000,
    parameter int unsigned RESP_TIMEOUT = 20000,
    parameter int unsigned GAP_CYCLES   = 400,
    parameter int unsigned MAX_RETRY    = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_polling_enable,
    input  logic                        i_reset_req,
    input  logic                        i_status_req,
    n64_poll_scheduler_if.master        txn_if,
    output logic [31:0]                 o_button_data,
    output logic [23:0]                 o_status_data,
    output logic                        o_data_valid,
    output logic                        o_controller_present,
    output logic [7:0]                  o_err_count
);

    localparam int unsigned POLL_W  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int unsigned TMO_W   = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]         r_state;
    logic [POLL_W-1:0]  r_poll_cnt;
    logic               r_poll_pend;
    logic               r_rst_pend;
    logic               r_stat_pend;
    logic               r_reset_req_q;
    logic [7:0]         r_cmd;
    logic [5:0]         r_rx_len;
    logic               r_is_poll;
    logic [RETRY_W-1:0] r_retry;
    logic               r_again;
    logic [TMO_W-1:0]   r_tmo;
    logic [GAP_W-1:0]   r_gap;
    logic [31:0]        r_button_data;
    logic [23:0]        r_status_data;
    logic               r_data_valid;
    logic               r_present;
    logic [7:0]         r_err_count;

    logic w_tick;
    logic w_rst_edge;
    logic w_any_pend;
    logic w_pick_rst;
    logic w_pick_stat;
    logic w_pick_poll;
    logic w_serve;
    logic w_start;
    logic w_ok;
    logic w_fail;
    logic w_can_retry;
    logic w_gap_end;

    assign w_tick      = i_polling_enable && (r_poll_cnt == POLL_W'(POLL_PERIOD - 1));
    assign w_rst_edge  = i_reset_req && !r_reset_req_q;
    assign w_any_pend  = r_rst_pend || r_stat_pend || r_poll_pend;
    // Fixed priority: reset > status > poll
    assign w_pick_rst  = r_rst_pend;
    assign w_pick_stat = !r_rst_pend && r_stat_pend;
    assign w_pick_poll = !r_rst_pend && !r_stat_pend && r_poll_pend;
    assign w_serve     = (r_state == S_IDLE) && w_any_pend;
    assign w_start     = (r_state == S_ISSUE) && !txn_if.txn_busy;
    assign w_ok        = (r_state == S_WAIT) && txn_if.txn_done && !txn_if.txn_err;
    // A done pulse in the timeout cycle takes precedence over the timeout
    assign w_fail      = (r_state == S_WAIT) && !w_ok &&
                         ((txn_if.txn_done && txn_if.txn_err) ||
                          (r_tmo == TMO_W'(RESP_TIMEOUT - 1)));
    assign w_can_retry = r_retry < RETRY_W'(MAX_RETRY);
    assign w_gap_end   = (r_state == S_GAP) && (r_gap == GAP_W'(GAP_CYCLES - 1));

    assign txn_if.txn_start  = w_start;
    assign txn_if.txn_cmd    = r_cmd;
    assign txn_if.txn_rx_len = r_rx_len;

    assign o_button_data        = r_button_data;
    assign o_status_data        = r_status_data;
    assign o_data_valid         = r_data_valid;
    assign o_controller_present = r_present;
    assign o_err_count          = r_err_count;

    // Request capture: a new request in the same cycle its flag is served re-arms the flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_poll_cnt    <= '0;
            r_poll_pend   <= 1'b0;
            r_rst_pend    <= 1'b0;
            r_stat_pend   <= 1'b0;
            r_reset_req_q <= 1'b0;
        end else begin
            r_reset_req_q <= i_reset_req;
            if (!i_polling_enable) begin
                r_poll_cnt  <= '0;
                r_poll_pend <= 1'b0;
            end else begin
                r_poll_cnt <= w_tick ? '0 : r_poll_cnt + POLL_W'(1);
                if (w_tick) begin
                    r_poll_pend <= 1'b1;
                end else if (w_serve && w_pick_poll) begin
                    r_poll_pend <= 1'b0;
                end
            end
            if (w_rst_edge) begin
                r_rst_pend <= 1'b1;
            end else if (w_serve && w_pick_rst) begin
                r_rst_pend <= 1'b0;
            end
            if (i_status_req) begin
                r_stat_pend <= 1'b1;
            end else if (w_serve && w_pick_stat) begin
                r_stat_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_cmd         <= 8'h00;
            r_rx_len      <= 6'd0;
            r_is_poll     <= 1'b0;
            r_retry       <= '0;
            r_again       <= 1'b0;
            r_tmo         <= '0;
            r_gap         <= '0;
            r_button_data <= 32'h0;
            r_status_data <= 24'h0;
            r_data_valid  <= 1'b0;
            r_present     <= 1'b0;
            r_err_count   <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_pend) begin
                        r_state   <= S_ISSUE;
                        r_retry   <= '0;
                        r_is_poll <= w_pick_poll;
                        r_cmd     <= w_pick_rst ? 8'hFF : (w_pick_stat ? 8'h00 : 8'h01);
                        r_rx_len  <= w_pick_poll ? 6'd32 : 6'd24;
                    end
                end
                S_ISSUE: begin
                    if (w_start) begin
                        r_state <= S_WAIT;
                        // The start cycle itself is cycle 0 of the response window
                        r_tmo   <= TMO_W'(1);
                    end
                end
                S_WAIT: begin
                    if (w_ok) begin
                        r_present <= 1'b1;
                        if (r_is_poll) begin
                            r_button_data <= txn_if.txn_rx_data;
                            r_data_valid  <= 1'b1;
                        end else begin
                            r_status_data <= txn_if.txn_rx_data[23:0];
                        end
                        r_again <= 1'b0;
                        r_gap   <= '0;
                        r_state <= S_GAP;
                    end else if (w_fail) begin
                        r_gap   <= '0;
                        r_state <= S_GAP;
                        if (w_can_retry) begin
                            r_retry <= r_retry + RETRY_W'(1);
                            r_again <= 1'b1;
                        end else begin
                            r_again   <= 1'b0;
                            r_present <= 1'b0;
                            if (r_is_poll) begin
                                r_data_valid <= 1'b0;
                            end
                            if (r_err_count != 8'hFF) begin
                                r_err_count <= r_err_count + 8'd1;
                            end
                        end
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_state <= r_again ? S_ISSUE : S_IDLE;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
